fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 120 ++++++++++++
 tb/tb_fetch_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO sitting between instruction memory and decode.
// Define FQ_JUMP_PREDECODE_EN to let fetch follow j-format jumps without waiting for a redirect.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [29:0]            redirect_pc,
  output logic                   im_req,
  output logic [29:0]            im_addr,
  input  logic                   im_ack,
  input  logic [31:0]            im_rdata,
  output logic                   ins_valid,
  output logic [31:0]            ins,
  output logic [29:0]            ins_pc_plus_4,
  input  logic                   ins_ready,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Handshakes: memory side is req/ack with at most one request in flight and im_addr held
  // until its ack (ack may land in the request cycle); decode side pops when ins_valid && ins_ready.
  logic [29:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          outstanding_q, outstanding_d;
  logic          discard_q, discard_d;
  logic          push, pop;
  logic [29:0]   pc_plus_1;
  logic [29:0]   next_pc;
  logic [31:0]   ins_mem_q [DEPTH];
  logic [29:0]   pc_mem_q  [DEPTH];

  assign pc_plus_1     = fetch_pc_q + 30'd1;
  assign im_addr       = fetch_pc_q;
  assign ins_valid     = (count_q != '0);
  assign ins           = ins_mem_q[rd_ptr_q];
  assign ins_pc_plus_4 = pc_mem_q[rd_ptr_q];
  assign count         = count_q;

`ifdef FQ_JUMP_PREDECODE_EN
  // A j instruction's target is fully known from its own word, so fetch can follow it directly.
  assign next_pc = (im_rdata[31:26] == 6'b000010) ? {pc_plus_1[29:26], im_rdata[25:0]}
                                                 : pc_plus_1;
`else
  assign next_pc = pc_plus_1;
`endif

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    im_req        = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    if (!rst) begin
      if (redirect) begin
        fetch_pc_d    = redirect_pc;
        count_d       = '0;
        rd_ptr_d      = wr_ptr_q;
        outstanding_d = 1'b0;
        // A request still in flight will be answered later with stale data; remember to drop it.
        discard_d     = (outstanding_q || discard_q) && !im_ack;
      end else begin
        im_req = !outstanding_q && !discard_q && (count_q < FULL);
        pop    = ins_valid && ins_ready;
        if (im_ack && discard_q) begin
          discard_d = 1'b0;
        end else if (im_ack && (outstanding_q || im_req)) begin
          push          = 1'b1;
          outstanding_d = 1'b0;
          fetch_pc_d    = next_pc;
        end else if (im_req) begin
          outstanding_d = 1'b1;
        end
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop) begin
          count_d = count_q + CW'(1);
        end else if (!push && pop) begin
          count_d = count_q - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ins_mem_q[wr_ptr_q] <= im_rdata;
      pc_mem_q[wr_ptr_q]  <= pc_plus_1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: memory responder, pop monitor with an expected queue, scenario tasks.
module tb_fetch_queue;
  logic        clk;
  logic        rst;
  logic        redirect;
  logic [29:0] redirect_pc;
  logic        im_req;
  logic [29:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        ins_valid;
  logic [31:0] ins;
  logic [29:0] ins_pc_plus_4;
  logic        ins_ready;
  logic [2:0]  count;

  logic [61:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  logic        resp_en   = 1'b0;
  logic        resp_busy = 1'b0;
  int          resp_wait = 0;
  int          ack_delay = 0;
  logic [29:0] resp_addr = '0;
  logic        jump_en   = 1'b0;

  fetch_queue #(.DEPTH(4), .RESET_PC(30'h0000_0C00)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
    .ins_valid(ins_valid), .ins(ins), .ins_pc_plus_4(ins_pc_plus_4),
    .ins_ready(ins_ready), .count(count)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (jump_en && a == 30'h0000_0C00) return 32'h0800_0040;
    return {a ^ 30'h1555_5555, 2'b11};
  endfunction

  task automatic push_seq(input logic [29:0] pc, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({mem_word(pc + 30'(i)), pc + 30'(i + 1)});
  endtask

  // Instruction memory: takes a request when idle, answers after ack_delay cycles.
  initial begin
    im_ack   = 1'b0;
    im_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      im_ack = 1'b0;
      if (!resp_en) begin
        resp_busy = 1'b0;
      end else begin
        if (!resp_busy && im_req) begin
          resp_busy = 1'b1;
          resp_addr = im_addr;
          resp_wait = ack_delay;
        end
        if (resp_busy) begin
          if (resp_wait == 0) begin
            im_ack    = 1'b1;
            im_rdata  = mem_word(resp_addr);
            resp_busy = 1'b0;
          end else begin
            resp_wait--;
          end
        end
      end
    end
  end

  // Scoreboard: every pop decode would accept is compared against the head of exp_q.
  initial begin
    logic [61:0] exp;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && !redirect && ins_valid && ins_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL pop_unexpected: got ins=%h pc_plus_4=%h, required no entry", ins, ins_pc_plus_4);
        end else begin
          exp = exp_q.pop_front();
          if ({ins, ins_pc_plus_4} !== exp)
            $display("FAIL pop_entry: got ins=%h pc_plus_4=%h, required ins=%h pc_plus_4=%h",
                     ins, ins_pc_plus_4, exp[61:30], exp[29:0]);
          else n_pass++;
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; ins_ready = 1'b0; resp_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++; if (im_req !== 1'b0) $display("FAIL reset_im_req: got %b required 0", im_req); else n_pass++;
      n_checks++; if (ins_valid !== 1'b0) $display("FAIL reset_ins_valid: got %b required 0", ins_valid); else n_pass++;
      n_checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d required 0", count); else n_pass++;
    end
  endtask

  task automatic test_sequential();
    @(negedge clk);
    rst = 1'b0; resp_en = 1'b1; ack_delay = 0; ins_ready = 1'b1;
    push_seq(30'h0000_0C00, 40);
    #2;
    n_checks++; if (count !== 3'd0) $display("FAIL release_count: got %0d required 0", count); else n_pass++;
    n_checks++; if (ins_valid !== 1'b0) $display("FAIL release_ins_valid: got %b required 0", ins_valid); else n_pass++;
    n_checks++; if (im_req !== 1'b1) $display("FAIL release_im_req: got %b required 1", im_req); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #2; end
      n_checks++;
      if (im_addr !== 30'h0000_0C00 + 30'(i))
        $display("FAIL seq_im_addr%0d: got %h required %h", i, im_addr, 30'h0000_0C00 + 30'(i));
      else n_pass++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_stall();
    @(negedge clk);
    ins_ready = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    n_checks++; if (count !== 3'd4) $display("FAIL stall_count: got %0d required 4", count); else n_pass++;
    n_checks++; if (im_req !== 1'b0) $display("FAIL stall_im_req: got %b required 0", im_req); else n_pass++;
    n_checks++; if (ins_valid !== 1'b1) $display("FAIL stall_ins_valid: got %b required 1", ins_valid); else n_pass++;
    ins_ready = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_redirect_pending();
    logic found = 1'b0;
    @(negedge clk);
    ack_delay = 3;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (resp_busy && resp_wait >= 1) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL rdp_wait_pending: got timeout required pending request"); else n_pass++;
    redirect = 1'b1; redirect_pc = 30'h100;
    exp_q.delete(); push_seq(30'h100, 20);
    @(negedge clk);
    redirect = 1'b0;
    #2;
    n_checks++; if (count !== 3'd0) $display("FAIL rdp_count: got %0d required 0", count); else n_pass++;
    n_checks++; if (ins_valid !== 1'b0) $display("FAIL rdp_ins_valid: got %b required 0", ins_valid); else n_pass++;
    n_checks++; if (im_req !== 1'b0) $display("FAIL rdp_im_req_blocked: got %b required 0", im_req); else n_pass++;
    n_checks++; if (im_addr !== 30'h100) $display("FAIL rdp_im_addr: got %h required 100", im_addr); else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk); #2;
      if (ins_valid) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL rdp_first_entry: got timeout required ins_pc_plus_4=101");
    else if (ins_pc_plus_4 !== 30'h101) $display("FAIL rdp_first_entry: got %h required 101", ins_pc_plus_4);
    else n_pass++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_redirect_collide();
    logic found = 1'b0;
    @(negedge clk);
    ack_delay = 1; ins_ready = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (resp_busy && resp_wait == 0 && ins_valid) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL rdc_wait_ack: got timeout required ack with entries queued"); else n_pass++;
    redirect = 1'b1; redirect_pc = 30'h200; ins_ready = 1'b1;
    exp_q.delete(); push_seq(30'h200, 20);
    @(negedge clk);
    redirect = 1'b0;
    #2;
    n_checks++; if (count !== 3'd0) $display("FAIL rdc_count: got %0d required 0", count); else n_pass++;
    n_checks++; if (ins_valid !== 1'b0) $display("FAIL rdc_ins_valid: got %b required 0", ins_valid); else n_pass++;
    n_checks++; if (im_req !== 1'b1) $display("FAIL rdc_im_req: got %b required 1", im_req); else n_pass++;
    n_checks++; if (im_addr !== 30'h200) $display("FAIL rdc_im_addr: got %h required 200", im_addr); else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk); #2;
      if (ins_valid) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL rdc_first_entry: got timeout required ins_pc_plus_4=201");
    else if (ins_pc_plus_4 !== 30'h201) $display("FAIL rdc_first_entry: got %h required 201", ins_pc_plus_4);
    else n_pass++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_jump();
    logic        found = 1'b0;
    logic [29:0] target;
`ifdef FQ_JUMP_PREDECODE_EN
    target = 30'h040;
`else
    target = 30'hC01;
`endif
    @(negedge clk);
    ack_delay = 0; ins_ready = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (!resp_busy) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL jmp_wait_idle: got timeout required idle memory"); else n_pass++;
    jump_en = 1'b1; redirect = 1'b1; redirect_pc = 30'hC00;
    exp_q.delete();
    exp_q.push_back({32'h0800_0040, 30'hC01});
    push_seq(target, 20);
    @(negedge clk);
    redirect = 1'b0;
    #2;
    n_checks++; if (im_addr !== 30'hC00) $display("FAIL jmp_first_addr: got %h required c00", im_addr); else n_pass++;
    @(negedge clk); #2;
    n_checks++; if (im_addr !== target) $display("FAIL jmp_next_addr: got %h required %h", im_addr, target); else n_pass++;
    jump_en = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    logic found = 1'b0;
    @(negedge clk);
    ack_delay = 2; ins_ready = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (count == 3'd3 && resp_busy) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL rst_wait_fill: got timeout required count=3 with pending request"); else n_pass++;
    rst = 1'b1;
    @(negedge clk); #2;
    n_checks++; if (count !== 3'd0) $display("FAIL rst_mid_count: got %0d required 0", count); else n_pass++;
    n_checks++; if (ins_valid !== 1'b0) $display("FAIL rst_mid_ins_valid: got %b required 0", ins_valid); else n_pass++;
    n_checks++; if (im_req !== 1'b0) $display("FAIL rst_mid_im_req: got %b required 0", im_req); else n_pass++;
    repeat (4) @(negedge clk);
    #2;
    n_checks++; if (count !== 3'd0) $display("FAIL rst_late_ack_count: got %0d required 0", count); else n_pass++;
    @(negedge clk);
    rst = 1'b0; ins_ready = 1'b1; ack_delay = 0;
    exp_q.delete(); push_seq(30'hC00, 20);
    #2;
    n_checks++; if (im_addr !== 30'hC00) $display("FAIL rst_resume_addr: got %h required c00", im_addr); else n_pass++;
    n_checks++; if (im_req !== 1'b1) $display("FAIL rst_resume_req: got %b required 1", im_req); else n_pass++;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_pending();
    test_redirect_collide();
    test_jump();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
